// File: rtl/cc_pkg.sv
// Shared types and constants for the code-calculator result unpacker.
// Width, option-bit and saturation definitions used by all cc_* blocks.
package cc_pkg;

    localparam int DATA_W = 4;
    localparam int NORM_W = DATA_W + 1;
    localparam int N_ELEM = 5;
    localparam int IDX_W  = 3;

    localparam int OPT_NORM = 0;
    localparam int OPT_ASC  = 1;
    localparam int OPT_REV  = 2;

    localparam int SAT_MAX = (2 ** (DATA_W - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DATA_W - 1));

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(N_ELEM - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

endpackage

// File: rtl/cc_denorm_sat.sv
// Adds the normalization offset back to one element and clamps the
// result into the signed DATA_W range, flagging any clamp.
module cc_denorm_sat
    import cc_pkg::*;
(
    input  logic signed [NORM_W-1:0] elem_i,
    input  logic signed [DATA_W-1:0] off_i,
    output logic signed [DATA_W-1:0] val_o,
    output logic                     sat_o
);

    logic signed [NORM_W:0] sum;

    // One guard bit above NORM_W keeps the sum exact before clamping
    always_comb begin
        sum = {elem_i[NORM_W-1], elem_i}
            + {{(NORM_W + 1 - DATA_W){off_i[DATA_W-1]}}, off_i};
        val_o = sum[DATA_W-1:0];
        sat_o = 1'b0;
        if (sum > SAT_MAX) begin
            val_o = DATA_W'(SAT_MAX);
            sat_o = 1'b1;
        end else if (sum < SAT_MIN) begin
            val_o = DATA_W'(SAT_MIN);
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/cc_result_unpacker.sv
// Captures one processed vector, restores scale, emits it beat by beat.
// Optional monotonicity check enabled by defining CC_ORDER_CHECK_EN.
module cc_result_unpacker
    import cc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_opt,
    input  logic signed [NORM_W-1:0] in_d0,
    input  logic signed [NORM_W-1:0] in_d1,
    input  logic signed [NORM_W-1:0] in_d2,
    input  logic signed [NORM_W-1:0] in_d3,
    input  logic signed [NORM_W-1:0] in_d4,
    input  logic signed [DATA_W-1:0] in_avg,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     out_sat,
    output logic                     out_order_err
);

    state_t                   state_q;
    logic signed [NORM_W-1:0] buf_q [N_ELEM];
    logic signed [DATA_W-1:0] off_q;
    logic                     rev_q;
    logic [IDX_W-1:0]         beat_q;
    logic signed [NORM_W-1:0] in_vec [N_ELEM];
    logic [IDX_W-1:0]         sel;
    logic                     emit;
    logic                     take;
    logic signed [DATA_W-1:0] dn_val;
    logic                     dn_sat;

    // Gather the flat input ports into an indexable vector
    always_comb begin
        in_vec[0] = in_d0;
        in_vec[1] = in_d1;
        in_vec[2] = in_d2;
        in_vec[3] = in_d3;
        in_vec[4] = in_d4;
    end

    assign emit = (state_q == EMIT);
    assign take = (state_q == IDLE) && in_valid;

    // Capture in IDLE, then step one beat per accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            off_q   <= '0;
            rev_q   <= 1'b0;
            for (int i = 0; i < N_ELEM; i++) buf_q[i] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= EMIT;
                        beat_q  <= '0;
                        off_q   <= in_opt[OPT_NORM] ? in_avg : '0;
                        rev_q   <= in_opt[OPT_REV];
                        for (int i = 0; i < N_ELEM; i++) buf_q[i] <= in_vec[i];
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q <= IDLE;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel = rev_q ? (LAST_BEAT - beat_q) : beat_q;

    cc_denorm_sat u_denorm (
        .elem_i (buf_q[sel]),
        .off_i  (off_q),
        .val_o  (dn_val),
        .sat_o  (dn_sat)
    );

    assign in_ready  = ~emit;
    assign out_valid = emit;
    assign out_data  = emit ? dn_val : '0;
    assign out_idx   = emit ? sel : '0;
    assign out_last  = emit && (beat_q == LAST_BEAT);
    assign out_sat   = emit && dn_sat;

`ifdef CC_ORDER_CHECK_EN
    logic bad;
    logic err_q;

    // Non-strict monotonic check in the direction given by the asc bit
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < N_ELEM - 1; i++) begin
            if (in_opt[OPT_ASC] ? (in_vec[i] > in_vec[i+1])
                                : (in_vec[i] < in_vec[i+1]))
                bad = 1'b1;
        end
    end

    // Hold the verdict for every beat of the captured vector
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else if (take) err_q <= bad;
    end

    assign out_order_err = emit && err_q;
`else
    logic unused_asc;
    assign unused_asc    = in_opt[OPT_ASC] ^ take;
    assign out_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_cc_result_unpacker.sv
// Directed plus randomized bench for cc_result_unpacker.
// Expected beats come from an arithmetic model of the restore rules.
module tb_cc_result_unpacker;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opt;
    logic signed [4:0] in_d0, in_d1, in_d2, in_d3, in_d4;
    logic signed [3:0] in_avg;
    logic              out_valid;
    logic              out_ready;
    logic signed [3:0] out_data;
    logic [2:0]        out_idx;
    logic              out_last;
    logic              out_sat;
    logic              out_order_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_result_unpacker dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opt        (in_opt),
        .in_d0         (in_d0),
        .in_d1         (in_d1),
        .in_d2         (in_d2),
        .in_d3         (in_d3),
        .in_d4         (in_d4),
        .in_avg        (in_avg),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_idx       (out_idx),
        .out_last      (out_last),
        .out_sat       (out_sat),
        .out_order_err (out_order_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_beat(input int b, input int ed, input int ei,
                            input int es, input int ee);
        chk($sformatf("out_valid b%0d", b), int'(out_valid), 1);
        chk($sformatf("in_ready b%0d", b), int'(in_ready), 0);
        chk($sformatf("out_data b%0d", b), int'(out_data), ed);
        chk($sformatf("out_idx b%0d", b), int'(out_idx), ei);
        chk($sformatf("out_last b%0d", b), int'(out_last), (b == 4) ? 1 : 0);
        chk($sformatf("out_sat b%0d", b), int'(out_sat), es);
        chk($sformatf("order_err b%0d", b), int'(out_order_err), ee);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        chk({tag, " out_idx"}, int'(out_idx), 0);
        chk({tag, " out_last"}, int'(out_last), 0);
        chk({tag, " out_sat"}, int'(out_sat), 0);
        chk({tag, " out_data"}, int'(out_data), 0);
        chk({tag, " order_err"}, int'(out_order_err), 0);
    endtask

    // Send one vector and check every beat; bp_beat/rst_beat < 0 disables
    task automatic do_vec(input logic [2:0] opt, input int d[5],
                          input int avg, input int bp_beat,
                          input int bp_n, input int rst_beat);
        int off, s, n;
        int ed[5], ei[5], es[5];
        int ee;
        off = opt[0] ? avg : 0;
        ee = 0;
`ifdef CC_ORDER_CHECK_EN
        for (int k = 0; k < 4; k++)
            if (opt[1] ? (d[k] > d[k+1]) : (d[k] < d[k+1])) ee = 1;
`endif
        for (int b = 0; b < 5; b++) begin
            ei[b] = opt[2] ? 4 - b : b;
            s = d[ei[b]] + off;
            ed[b] = (s > 7) ? 7 : ((s < -8) ? -8 : s);
            es[b] = (s > 7 || s < -8) ? 1 : 0;
        end
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready idle", int'(in_ready), 1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_opt = opt;
        in_d0 = 5'(d[0]);
        in_d1 = 5'(d[1]);
        in_d2 = 5'(d[2]);
        in_d3 = 5'(d[3]);
        in_d4 = 5'(d[4]);
        in_avg = 4'(avg);
        @(negedge clk);
        in_opt = 3'($urandom);
        in_d0 = 5'($urandom);
        in_d1 = 5'($urandom);
        in_d2 = 5'($urandom);
        in_d3 = 5'($urandom);
        in_d4 = 5'($urandom);
        in_avg = 4'($urandom);
        for (int b = 0; b < 5; b++) begin
            chk_beat(b, ed[b], ei[b], es[b], ee);
            if (b == rst_beat) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk_reset_vals("mid-reset");
                return;
            end
            if (b == bp_beat) begin
                out_ready = 1'b0;
                repeat (bp_n) begin
                    @(negedge clk);
                    chk_beat(b, ed[b], ei[b], es[b], ee);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("done out_valid", int'(out_valid), 0);
        chk("done in_ready", int'(in_ready), 1);
    endtask

    initial begin
        int v[5];
        logic [2:0] opt;
        int bp, rb;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_opt = '0;
        in_d0 = '0;
        in_d1 = '0;
        in_d2 = '0;
        in_d3 = '0;
        in_d4 = '0;
        in_avg = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        v = '{-4, -2, 1, 3, 5};
        do_vec(3'b011, v, 2, -1, 0, -1);
        do_vec(3'b111, v, 2, -1, 0, -1);
        v = '{7, 6, 5, 0, -8};
        do_vec(3'b000, v, 3, -1, 0, -1);
        v = '{15, -16, 0, 1, -1};
        do_vec(3'b001, v, 7, -1, 0, -1);
        v = '{-4, -2, 1, 3, 5};
        do_vec(3'b011, v, 2, 2, 3, -1);
        do_vec(3'b011, v, 2, 2, 3, 3);
        v = '{1, 0, 2, 3, 4};
        do_vec(3'b010, v, 0, -1, 0, -1);
        v = '{0, 1, 2, 3, 4};
        do_vec(3'b010, v, 0, -1, 0, -1);

        for (int t = 0; t < 30; t++) begin
            opt = 3'($urandom);
            for (int k = 0; k < 5; k++) v[k] = int'($urandom_range(0, 31)) - 16;
            if ($urandom_range(0, 1) == 1) begin
                v.sort();
                if (!opt[1]) v.reverse();
            end
            bp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
            rb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            do_vec(opt, v, int'($urandom_range(0, 15)) - 8,
                   bp, int'($urandom_range(1, 3)), rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
